// File: rtl/dbus_to_cbus_mp.sv
// Registered multi-port DBus-to-CBus bridge: arbitrates NUM_PORTS masters, holds one request, issues it as a single-beat CBus transaction.
// Define DBUS_BRIDGE_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
package dbus_to_cbus_mp_pkg;
  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;
  typedef logic [1:0] axi_burst_t;

  localparam mlen_t      MLEN1           = 4'd0;
  localparam axi_burst_t AXI_BURST_FIXED = 2'b00;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module dbus_to_cbus_mp
  import dbus_to_cbus_mp_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  dbus_req_t  [NUM_PORTS-1:0]  dreq,
  output dbus_resp_t [NUM_PORTS-1:0]  dresp,
  output cbus_req_t                   dcreq,
  input  cbus_resp_t                  dcresp,
  output logic                        busy,
  output logic       [PORT_W-1:0]     grant
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [31:0]     hold_addr, hold_data;
  msize_t          hold_size;
  logic [3:0]      hold_strobe;
  logic [PORT_W-1:0] hold_port;

  logic              any_valid;
  logic [PORT_W-1:0] win;
  logic              okay;
  logic              capture;

`ifdef DBUS_BRIDGE_RR_EN
  logic [PORT_W-1:0] rr_last;
  logic [PORT_W-1:0] cand;

  // Search starts one past the previous winner so every requester is served in turn.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = PORT_W'((int'(rr_last) + k) % NUM_PORTS);
      if (!any_valid && dreq[cand].valid) begin
        any_valid = 1'b1;
        win       = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rr_last <= PORT_W'(NUM_PORTS - 1);
    else if (capture) rr_last <= win;
  end
`else
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (dreq[i].valid) begin
        any_valid = 1'b1;
        win       = PORT_W'(i);
      end
    end
  end
`endif

  assign capture = (state == IDLE) && any_valid;
  assign okay    = (state == BUSY) && dcresp.ready && dcresp.last;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BUSY;
      BUSY:    if (okay)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // The holding registers are few and feed outputs, so they are reset too rather than left undefined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold_addr   <= '0;
      hold_data   <= '0;
      hold_size   <= '0;
      hold_strobe <= '0;
      hold_port   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_addr   <= dreq[win].addr;
        hold_data   <= dreq[win].data;
        hold_size   <= dreq[win].size;
        hold_strobe <= dreq[win].strobe;
        hold_port   <= win;
      end
    end
  end

  // Responses are combinational from dcresp and state only; dreq never reaches dresp.
  always_comb begin
    dcreq = '0;
    dresp = '0;
    if (state == BUSY) begin
      dcreq.valid    = 1'b1;
      dcreq.is_write = |hold_strobe;
      dcreq.size     = hold_size;
      dcreq.addr     = hold_addr;
      dcreq.strobe   = hold_strobe;
      dcreq.data     = hold_data;
      dcreq.len      = MLEN1;
      dcreq.burst    = AXI_BURST_FIXED;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (okay && hold_port == PORT_W'(i)) begin
        dresp[i].addr_ok = 1'b1;
        dresp[i].data_ok = 1'b1;
        dresp[i].data    = dcresp.data;
      end
    end
  end

  assign busy  = (state == BUSY);
  assign grant = hold_port;

endmodule

// File: doc/dbus_to_cbus_mp.md
# dbus_to_cbus_mp

Multi-port, registered DBus-to-CBus bridge. Arbitrates among `NUM_PORTS` DBus masters (e.g. data cache, uncached path, debug port), captures the winning request into a holding register, and issues it as a single-beat CBus transaction. Unlike the single-port combinational bridge, it decouples downstream timing from the masters and supports more than one master. It sits between the core-side DBus masters and the CBus arbiter/router.

## Interface
Parameters:
- `NUM_PORTS`, 2, number of DBus masters (1..8).
- `PORT_W`, `$clog2(NUM_PORTS)` (min 1), grant index width; derived, do not override.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dreq`  in  `dbus_req_t [NUM_PORTS-1:0]`  per-port DBus requests.
- `dresp`  out  `dbus_resp_t [NUM_PORTS-1:0]`  per-port DBus responses.
- `dcreq`  out  `cbus_req_t`  CBus request.
- `dcresp`  in  `cbus_resp_t`  CBus response.
- `busy`  out  1  high while a transaction is held (state BUSY).
- `grant`  out  `PORT_W`  index of held port; valid only when `busy`.

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, BUSY.
- IDLE: if any `dreq[i].valid`, select a winner (see Configuration), capture its `addr`, `size`, `strobe`, `data` and index into holding registers, go to BUSY. No valid -> stay IDLE.
- BUSY: `dcreq` is driven only from holding registers: `valid`=1, `is_write`=`|strobe`, `size`, `addr`, `strobe`, `data` from the register; `len`=`MLEN1`; `burst`=`AXI_BURST_FIXED`. Changes on `dreq` during BUSY are ignored.
- Completion: in BUSY, `okay = dcresp.ready && dcresp.last`. When `okay`, the held port gets `addr_ok`=1, `data_ok`=1, `data`=`dcresp.data` in that same cycle (combinational); next state IDLE.
- Non-held ports always see `addr_ok`=0, `data_ok`=0, `data`=0. In IDLE all ports see 0.
- A master keeps `valid` and payload stable until its `data_ok`. `valid` still high in the cycle after `data_ok` is a new request.
- `dcreq.valid`=0 in IDLE; other `dcreq` fields in IDLE are 0.
- Write strobes pass through unchanged; CBus has no write-enable mask beyond `strobe`.

## Timing
- Reset values: state IDLE, holding registers 0, `dcreq.valid`=0, all `dresp` fields 0, `busy`=0, `grant`=0, RR pointer = `NUM_PORTS-1`.
- Latency: request seen in IDLE at cycle T -> `dcreq.valid` high at T+1. Earliest `data_ok` at T+1 if `dcresp.ready && last` that cycle.
- Back-to-back: completion at cycle C -> IDLE at C+1 -> next `dcreq.valid` at C+2 (one bubble).
- Multi-cycle `ready` low: BUSY held, `dcreq` stable, no response.
- `dcresp.ready` without `last`: not a completion; stays BUSY (single-beat `MLEN1` means `last` is expected with `ready`).
- Simultaneous valids in IDLE: exactly one winner; losers wait, no response.
- Reset mid-transaction: immediately IDLE, `dcreq.valid`=0, no `data_ok` issued; downstream recovery is the system reset's responsibility.
- Response signals are never registered; `dresp` depends combinationally on `dcresp` and state only (no path from `dreq` to `dresp`).

## Configuration
- `DBUS_BRIDGE_RR_EN` defined: round-robin arbitration. Pointer `last` holds the most recent grant; search starts at `last+1` modulo `NUM_PORTS`; `last` updates on each IDLE->BUSY capture.
- Not defined: fixed priority, lowest index wins; no pointer register (reset value list excludes it).

## Test plan
- Single read, port 0, `addr`=0x8000_1000, `strobe`=0, `dcresp.ready&&last` two cycles after `dcreq.valid` -> `dcreq.is_write`=0, `len`=MLEN1; port 0 `data_ok`=1 with `data`=0xDEAD_BEEF same cycle; port 1 sees 0.
- Write, port 1, `strobe`=0x0F, `data`=0x1234_5678 -> `dcreq.is_write`=1, `strobe`=0x0F, `data` passes; payload change on `dreq[1]` mid-BUSY does not alter `dcreq`.
- Ports 0 and 1 both valid continuously, 4 transactions: with `DBUS_BRIDGE_RR_EN` grants 0,1,0,1; without, grants 0,0,0,0.
- `ready` held low 10 cycles -> `busy`=1, `dcreq` stable, no `data_ok`; one-cycle bubble between completion and next `dcreq.valid`.
- Assert `reset` while BUSY -> `dcreq.valid`=0 and all `dresp` 0 immediately (before next edge); after release a fresh request completes normally.
- `NUM_PORTS`=4, ports 1 and 3 valid -> RR grants 1,3,1; fixed priority grants 1,1,1.
